// File: rtl/indirect_residual.sv
// Residual statistics between matched pixel positions and their delayed projections.
// Samples are delayed LAT cycles to meet the projection, differenced, then accumulated per frame.
module indirect_residual #(
  parameter int unsigned H_BW   = 10,
  parameter int unsigned V_BW   = 9,
  parameter int unsigned LAT    = 11,
  parameter int unsigned ACC_BW = 32,
  parameter int unsigned CNT_BW = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [H_BW-1:0]   i_idx1_x,
  input  logic [V_BW-1:0]   i_idx1_y,
  input  logic              i_proj_valid,
  input  logic [H_BW-1:0]   i_proj_x,
  input  logic [V_BW-1:0]   i_proj_y,
  input  logic              i_frame_start,
  input  logic              i_frame_end,
  input  logic              r_mode,
  input  logic [H_BW-1:0]   r_thr,
  output logic              o_valid,
  output logic [H_BW:0]     o_diffs_x,
  output logic [V_BW:0]     o_diffs_y,
  output logic              o_inlier,
  output logic [CNT_BW-1:0] o_inlier_cnt,
  output logic [ACC_BW-1:0] o_sq_sum,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned MW    = (H_BW > V_BW) ? H_BW : V_BW;
  localparam int unsigned AW    = MW + 1;
  localparam int unsigned SQ_W  = 2 * AW + 1;
  localparam int unsigned SUM_W = ((ACC_BW > SQ_W) ? ACC_BW : SQ_W) + 1;
  localparam int unsigned FC_W  = $clog2(LAT + 3);
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(LAT + 1);
  localparam logic [SUM_W-1:0] ACC_MAX_W  = SUM_W'({ACC_BW{1'b1}});

  typedef enum logic [1:0] {StIdle, StAccum, StFlush, StDone} state_e;

  state_e          state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            done_d;

  logic            restart;
  logic            accept_in;
  logic [LAT-1:0]  vpipe_q;
  logic [H_BW-1:0] xpipe_q [LAT];
  logic [V_BW-1:0] ypipe_q [LAT];
  logic            dly_valid, pair, mismatch;

  logic            s1_valid_q;
  logic [H_BW:0]   s1_dx_q;
  logic [V_BW:0]   s1_dy_q;

  logic [H_BW:0]      abs_x_raw;
  logic [V_BW:0]      abs_y_raw;
  logic [AW-1:0]      ax, ay, thr_ext;
  logic [2*AW-1:0]    sqx, sqy;
  logic [SQ_W-1:0]    sq;
  logic [SUM_W-1:0]   sum_wide;
  logic [ACC_BW-1:0]  sum_sat;
  logic [CNT_BW-1:0]  cnt_sat;
  logic               inlier_c, s2_take;

  // A frame start is honoured everywhere except while flushing.
  assign restart   = i_frame_start && (state_q != StFlush);
  assign accept_in = i_valid && (state_q == StAccum);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_frame_start) state_d = StAccum;
      end
      StAccum: begin
        if (!i_frame_start && i_frame_end) begin
          state_d = StFlush;
          fcnt_d  = '0;
        end
      end
      StFlush: begin
        if (fcnt_q == FLUSH_LAST) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          fcnt_d = fcnt_q + FC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vpipe_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        xpipe_q[i] <= '0;
        ypipe_q[i] <= '0;
      end
    end else begin
      vpipe_q[0] <= accept_in && !restart;
      xpipe_q[0] <= i_idx1_x;
      ypipe_q[0] <= i_idx1_y;
      for (int i = 1; i < LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1] && !restart;
        xpipe_q[i] <= xpipe_q[i-1];
        ypipe_q[i] <= ypipe_q[i-1];
      end
    end
  end

  assign dly_valid = vpipe_q[LAT-1];
  assign pair      = dly_valid && i_proj_valid;
  assign mismatch  = dly_valid ^ i_proj_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_dx_q    <= '0;
      s1_dy_q    <= '0;
    end else begin
      s1_valid_q <= pair && !restart;
      if (pair) begin
        s1_dx_q <= {1'b0, xpipe_q[LAT-1]} - {1'b0, i_proj_x};
        s1_dy_q <= {1'b0, ypipe_q[LAT-1]} - {1'b0, i_proj_y};
      end
    end
  end

  assign abs_x_raw = s1_dx_q[H_BW] ? -s1_dx_q : s1_dx_q;
  assign abs_y_raw = s1_dy_q[V_BW] ? -s1_dy_q : s1_dy_q;
  assign ax        = AW'(abs_x_raw);
  assign ay        = AW'(abs_y_raw);
  assign thr_ext   = AW'(r_thr);
  assign inlier_c  = !r_mode || ((ax <= thr_ext) && (ay <= thr_ext));
  assign sqx       = (2*AW)'(ax) * (2*AW)'(ax);
  assign sqy       = (2*AW)'(ay) * (2*AW)'(ay);
  assign sq        = SQ_W'(sqx) + SQ_W'(sqy);
  assign sum_wide  = SUM_W'(o_sq_sum) + SUM_W'(sq);
  assign sum_sat   = (sum_wide > ACC_MAX_W) ? '1 : sum_wide[ACC_BW-1:0];
  assign cnt_sat   = (&o_inlier_cnt) ? o_inlier_cnt : o_inlier_cnt + CNT_BW'(1);
  assign s2_take   = s1_valid_q && !restart;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_diffs_x    <= '0;
      o_diffs_y    <= '0;
      o_inlier     <= 1'b0;
      o_inlier_cnt <= '0;
      o_sq_sum     <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_valid <= s2_take;
      o_done  <= done_d;
      if (s2_take) begin
        o_diffs_x <= s1_dx_q;
        o_diffs_y <= s1_dy_q;
        o_inlier  <= inlier_c;
      end
      if (restart) begin
        o_inlier_cnt <= '0;
        o_sq_sum     <= '0;
        o_err        <= 1'b0;
      end else begin
        if (mismatch) o_err <= 1'b1;
        if (s1_valid_q && inlier_c) begin
          o_inlier_cnt <= cnt_sat;
          o_sq_sum     <= sum_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_indirect_residual.sv
// Bench for indirect_residual: directed vector table, corner sequences, randomized frames
// checked against an arithmetic per-frame model; a second instance has an 8-bit accumulator.
module tb_indirect_residual;
  localparam int unsigned H_BW = 10, V_BW = 9, LAT = 11, ACC_BW = 32, CNT_BW = 20;

  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_valid, i_proj_valid, i_frame_start, i_frame_end, r_mode;
  logic [H_BW-1:0] i_idx1_x, i_proj_x, r_thr;
  logic [V_BW-1:0] i_idx1_y, i_proj_y;

  logic o_valid, o_inlier, o_done, o_err;
  logic [H_BW:0] o_diffs_x;
  logic [V_BW:0] o_diffs_y;
  logic [CNT_BW-1:0] o_inlier_cnt;
  logic [ACC_BW-1:0] o_sq_sum;

  logic o8_valid, o8_inlier, o8_done, o8_err;
  logic [H_BW:0] o8_diffs_x;
  logic [V_BW:0] o8_diffs_y;
  logic [CNT_BW-1:0] o8_inlier_cnt;
  logic [7:0] o8_sq_sum;

  indirect_residual #(.H_BW(H_BW), .V_BW(V_BW), .LAT(LAT), .ACC_BW(ACC_BW), .CNT_BW(CNT_BW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_idx1_x(i_idx1_x),
    .i_idx1_y(i_idx1_y), .i_proj_valid(i_proj_valid), .i_proj_x(i_proj_x),
    .i_proj_y(i_proj_y), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .r_mode(r_mode), .r_thr(r_thr), .o_valid(o_valid), .o_diffs_x(o_diffs_x),
    .o_diffs_y(o_diffs_y), .o_inlier(o_inlier), .o_inlier_cnt(o_inlier_cnt),
    .o_sq_sum(o_sq_sum), .o_done(o_done), .o_err(o_err)
  );

  indirect_residual #(.H_BW(H_BW), .V_BW(V_BW), .LAT(LAT), .ACC_BW(8), .CNT_BW(CNT_BW)) dut8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_idx1_x(i_idx1_x),
    .i_idx1_y(i_idx1_y), .i_proj_valid(i_proj_valid), .i_proj_x(i_proj_x),
    .i_proj_y(i_proj_y), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .r_mode(r_mode), .r_thr(r_thr), .o_valid(o8_valid), .o_diffs_x(o8_diffs_x),
    .o_diffs_y(o8_diffs_y), .o_inlier(o8_inlier), .o_inlier_cnt(o8_inlier_cnt),
    .o_sq_sum(o8_sq_sum), .o_done(o8_done), .o_err(o8_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;

  typedef struct {
    logic   mode;
    int     thr, x, y, px, py;
    int     dx, dy;
    logic   inl;
    longint sq;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_idx1_x = '0; i_idx1_y = '0;
    i_proj_valid = 1'b0; i_proj_x = '0; i_proj_y = '0;
    i_frame_start = 1'b0; i_frame_end = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 64'(o_valid), 0);
    check({name, "_dx"}, 64'(o_diffs_x), 0);
    check({name, "_dy"}, 64'(o_diffs_y), 0);
    check({name, "_inl"}, 64'(o_inlier), 0);
    check({name, "_cnt"}, 64'(o_inlier_cnt), 0);
    check({name, "_sq"}, 64'(o_sq_sum), 0);
    check({name, "_done"}, 64'(o_done), 0);
    check({name, "_err"}, 64'(o_err), 0);
  endtask

  function automatic longint sat8(input longint v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Counts cycles from the frame_end cycle to o_done, bounded.
  task automatic end_frame_and_time(output int n);
    i_frame_end = 1'b1; tick(); i_frame_end = 1'b0;
    n = 1;
    while (!o_done && n < 40) begin tick(); n++; end
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int n;
    r_mode = v.mode; r_thr = H_BW'(v.thr);
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    i_valid = 1'b1; i_idx1_x = H_BW'(v.x); i_idx1_y = V_BW'(v.y);
    tick(); i_valid = 1'b0;
    repeat (LAT - 1) tick();
    i_proj_valid = 1'b1; i_proj_x = H_BW'(v.px); i_proj_y = V_BW'(v.py);
    tick(); i_proj_valid = 1'b0;
    check($sformatf("v%0d_early_valid", idx), 64'(o_valid), 0);
    tick();
    check($sformatf("v%0d_valid", idx), 64'(o_valid), 1);
    check($sformatf("v%0d_dx", idx), 64'($signed(o_diffs_x)), 64'(v.dx));
    check($sformatf("v%0d_dy", idx), 64'($signed(o_diffs_y)), 64'(v.dy));
    check($sformatf("v%0d_inl", idx), 64'(o_inlier), 64'(v.inl));
    check($sformatf("v%0d_sq", idx), 64'(o_sq_sum), v.sq);
    check($sformatf("v%0d_cnt", idx), 64'(o_inlier_cnt), 64'(v.inl));
    check($sformatf("v%0d_sq8", idx), 64'(o8_sq_sum), sat8(v.sq));
    check($sformatf("v%0d_err", idx), 64'(o_err), 0);
    tick();
    check($sformatf("v%0d_valid_off", idx), 64'(o_valid), 0);
    check($sformatf("v%0d_dx_hold", idx), 64'($signed(o_diffs_x)), 64'(v.dx));
    check($sformatf("v%0d_inl_hold", idx), 64'(o_inlier), 64'(v.inl));
    end_frame_and_time(n);
    check($sformatf("v%0d_done_lat", idx), 64'(n), 14);
    tick();
    check($sformatf("v%0d_done_pulse", idx), 64'(o_done), 0);
    check($sformatf("v%0d_sq_held", idx), 64'(o_sq_sum), v.sq);
  endtask

  task automatic random_frame(input int fidx);
    logic sv [128]; logic spv [128]; logic ev [128]; logic ein [128];
    int sx [128]; int sy [128]; int spx [128]; int spy [128]; int edx [128]; int edy [128];
    int n, len, done_v, thr, px, py, dx, dy, v;
    logic mode;
    longint m_sum, m_sum8;
    int m_cnt;
    for (int k = 0; k < 128; k++) begin
      sv[k] = 0; spv[k] = 0; ev[k] = 0; ein[k] = 0;
      sx[k] = 0; sy[k] = 0; spx[k] = 0; spy[k] = 0; edx[k] = 0; edy[k] = 0;
    end
    n = int'($urandom_range(20, 50));
    len = n + LAT + 6;
    done_v = n + LAT + 3;
    mode = 1'($urandom_range(0, 1));
    thr = int'($urandom_range(0, 30));
    for (int k = 1; k <= n; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        sv[k] = 1; sx[k] = int'($urandom_range(0, 1023)); sy[k] = int'($urandom_range(0, 511));
        if ($urandom_range(0, 3) == 0) begin
          px = int'($urandom_range(0, 1023)); py = int'($urandom_range(0, 511));
        end else begin
          px = sx[k] + int'($urandom_range(0, 40)) - 20;
          py = sy[k] + int'($urandom_range(0, 40)) - 20;
          px = (px < 0) ? 0 : ((px > 1023) ? 1023 : px);
          py = (py < 0) ? 0 : ((py > 511) ? 511 : py);
        end
        spv[k+LAT] = 1; spx[k+LAT] = px; spy[k+LAT] = py;
        dx = sx[k] - px; dy = sy[k] - py;
        ev[k+LAT+2] = 1; edx[k+LAT+2] = dx; edy[k+LAT+2] = dy;
        ein[k+LAT+2] = !mode || (iabs(dx) <= thr && iabs(dy) <= thr);
      end
    end
    // Strays after frame end must be discarded.
    for (int k = n + 1; k < len; k++) begin
      sv[k] = 1'($urandom_range(0, 1)); sx[k] = int'($urandom_range(0, 1023));
    end
    r_mode = mode; r_thr = H_BW'(thr);
    m_sum = 0; m_sum8 = 0; m_cnt = 0;
    for (int k = 0; k < len; k++) begin
      i_frame_start = (k == 0); i_frame_end = (k == n);
      i_valid = sv[k]; i_idx1_x = H_BW'(sx[k]); i_idx1_y = V_BW'(sy[k]);
      i_proj_valid = spv[k]; i_proj_x = H_BW'(spx[k]); i_proj_y = V_BW'(spy[k]);
      tick();
      v = k + 1;
      check($sformatf("r%0d_c%0d_valid", fidx, v), 64'(o_valid), 64'(ev[v]));
      check($sformatf("r%0d_c%0d_valid8", fidx, v), 64'(o8_valid), 64'(ev[v]));
      if (ev[v]) begin
        if (ein[v]) begin
          m_cnt++;
          m_sum = m_sum + longint'(edx[v] * edx[v] + edy[v] * edy[v]);
          m_sum8 = sat8(m_sum8 + longint'(edx[v] * edx[v] + edy[v] * edy[v]));
        end
        check($sformatf("r%0d_c%0d_dx", fidx, v), 64'($signed(o_diffs_x)), 64'(edx[v]));
        check($sformatf("r%0d_c%0d_dy", fidx, v), 64'($signed(o_diffs_y)), 64'(edy[v]));
        check($sformatf("r%0d_c%0d_inl", fidx, v), 64'(o_inlier), 64'(ein[v]));
        check($sformatf("r%0d_c%0d_inl8", fidx, v), 64'(o8_inlier), 64'(ein[v]));
      end
      check($sformatf("r%0d_c%0d_cnt", fidx, v), 64'(o_inlier_cnt), 64'(m_cnt));
      check($sformatf("r%0d_c%0d_cnt8", fidx, v), 64'(o8_inlier_cnt), 64'(m_cnt));
      check($sformatf("r%0d_c%0d_sq", fidx, v), 64'(o_sq_sum), m_sum);
      check($sformatf("r%0d_c%0d_sq8", fidx, v), 64'(o8_sq_sum), m_sum8);
      check($sformatf("r%0d_c%0d_done", fidx, v), 64'(o_done), 64'(v == done_v));
      check($sformatf("r%0d_c%0d_done8", fidx, v), 64'(o8_done), 64'(v == done_v));
      check($sformatf("r%0d_c%0d_err", fidx, v), 64'(o_err | o8_err), 0);
    end
    idle_inputs();
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b0, 0,    100, 50,  97,   55,  3,     -5,   1'b1, 34};
    tbl[1] = '{1'b1, 4,    100, 50,  97,   55,  3,     -5,   1'b0, 0};
    tbl[2] = '{1'b1, 5,    100, 50,  97,   55,  3,     -5,   1'b1, 34};
    tbl[3] = '{1'b0, 0,    0,   0,   1023, 511, -1023, -511, 1'b1, 1307650};
    tbl[4] = '{1'b0, 0,    1023, 511, 0,   0,   1023,  511,  1'b1, 1307650};
    tbl[5] = '{1'b1, 0,    7,   7,   7,    7,   0,     0,    1'b1, 0};
    tbl[6] = '{1'b1, 1023, 1023, 0,  0,    511, 1023,  -511, 1'b1, 1307650};

    idle_inputs(); r_mode = 1'b0; r_thr = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("rst");
    i_rst_n = 1'b1;
    tick();
    check_all_zero("post_rst");

    for (int i = 0; i < 7; i++) run_vector(i, tbl[i]);

    // Three dx=dy=1 samples, last one on the frame_end cycle.
    r_mode = 1'b0;
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      i_valid = (k < 3); i_idx1_x = 10'd11; i_idx1_y = 9'd21;
      i_frame_end = (k == 2);
      i_proj_valid = (k >= LAT && k < LAT + 3); i_proj_x = 10'd10; i_proj_y = 9'd20;
      tick();
      check($sformatf("a_valid_%0d", k + 1), 64'(o_valid), 64'(k + 1 >= 13 && k + 1 <= 15));
      check($sformatf("a_done_%0d", k + 1), 64'(o_done), 64'(k + 1 == 16));
    end
    idle_inputs();
    check("a_cnt", 64'(o_inlier_cnt), 3);
    check("a_sq", 64'(o_sq_sum), 6);
    i_valid = 1'b1; tick(); tick(); i_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("a_done_stray_valid", 64'(o_valid), 0);
    end
    check("a_cnt_held", 64'(o_inlier_cnt), 3);
    check("a_sq_held", 64'(o_sq_sum), 6);
    check("a_err", 64'(o_err), 0);

    // Missing projection, projection without sample, start/end collision.
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    i_valid = 1'b1; i_idx1_x = 10'd5; i_idx1_y = 9'd5; tick(); i_valid = 1'b0;
    repeat (LAT - 1) tick();
    check("b_err_before", 64'(o_err), 0);
    tick();
    check("b_err_set", 64'(o_err), 1);
    for (int k = 0; k < 4; k++) begin
      check("b_no_valid", 64'(o_valid), 0);
      check("b_err_sticky", 64'(o_err), 1);
      tick();
    end
    i_frame_start = 1'b1; i_frame_end = 1'b1; tick(); idle_inputs();
    check("b_err_clr", 64'(o_err), 0);
    i_proj_valid = 1'b1; tick(); i_proj_valid = 1'b0;
    check("b_err_proj_only", 64'(o_err), 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("b_no_done_collision", 64'(o_done), 0);
    end
    end_frame_and_time(n);
    check("b_done_lat", 64'(n), 14);
    check("b_err_in_done", 64'(o_err), 1);
    tick();

    // Saturation in the 8-bit accumulator: 200 then 255.
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      i_valid = (k == 0 || k == 3); i_idx1_x = 10'd20; i_idx1_y = 9'd20;
      i_proj_valid = (k == LAT || k == LAT + 3); i_proj_x = 10'd10; i_proj_y = 9'd10;
      tick();
      if (k + 1 == 13) begin
        check("c_sq8_first", 64'(o8_sq_sum), 200);
        check("c_sq_first", 64'(o_sq_sum), 200);
      end
      if (k + 1 == 16) begin
        check("c_sq8_sat", 64'(o8_sq_sum), 255);
        check("c_sq_second", 64'(o_sq_sum), 400);
        check("c_cnt8", 64'(o8_inlier_cnt), 2);
      end
    end
    idle_inputs();
    end_frame_and_time(n);
    check("c_done_lat", 64'(n), 14);
    check("c_sq8_held", 64'(o8_sq_sum), 255);
    tick();

    for (int f = 0; f < 6; f++) random_frame(f);

    // Reset while flushing, with a sample still in flight.
    r_mode = 1'b0;
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      i_valid = (k == 0 || k == 12); i_idx1_x = 10'd3; i_idx1_y = 9'd3;
      i_proj_valid = (k == LAT); i_proj_x = 10'd1; i_proj_y = 9'd1;
      i_frame_end = (k == 13);
      tick();
    end
    idle_inputs();
    check("d_pre_cnt", 64'(o_inlier_cnt), 1);
    check("d_pre_sq", 64'(o_sq_sum), 8);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("d_rst");
    tick(); tick();
    i_rst_n = 1'b1;
    i_valid = 1'b1; i_idx1_x = 10'd9; tick(); tick(); i_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("d_no_valid", 64'(o_valid), 0);
      check("d_no_done", 64'(o_done), 0);
      check("d_no_err", 64'(o_err), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/indirect_residual.md
INDIRECT_RESIDUAL -- requirements
Module: indirect_residual

Interface
REQ-001 SHALL have parameter H_BW, default 10: width of horizontal pixel index.
REQ-002 SHALL have parameter V_BW, default 9: width of vertical pixel index.
REQ-003 SHALL have parameter LAT, default 11, legal range 1..32: cycles from i_valid to the matching i_proj_valid.
REQ-004 SHALL have parameter ACC_BW, default 32: width of the squared-residual accumulator.
REQ-005 SHALL have parameter CNT_BW, default 20: width of the inlier counter.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: i_clk  input  1  clock; i_rst_n  input  1  async active-low reset.
REQ-007 SHALL have the following ports:
- i_valid  input  1  match sample valid
- i_idx1_x  input  H_BW  matched x, unsigned
- i_idx1_y  input  V_BW  matched y, unsigned
- i_proj_valid  input  1  projection valid, LAT cycles after i_valid
- i_proj_x  input  H_BW  projected x, unsigned
- i_proj_y  input  V_BW  projected y, unsigned
- i_frame_start  input  1  single-cycle pulse
- i_frame_end  input  1  single-cycle pulse
- r_mode  input  1  0 = accept all samples, 1 = reject outliers
- r_thr  input  H_BW  per-axis absolute residual threshold
- o_valid  output  1  residual valid
- o_diffs_x  output  H_BW+1  signed idx1_x - proj_x
- o_diffs_y  output  V_BW+1  signed idx1_y - proj_y
- o_inlier  output  1  sample accepted
- o_inlier_cnt  output  CNT_BW  accepted samples this frame
- o_sq_sum  output  ACC_BW  sum of dx^2+dy^2 over accepted samples
- o_done  output  1  one-cycle frame-complete pulse
- o_err  output  1  sticky alignment error

Function
REQ-008 SHALL implement states IDLE, ACCUM, FLUSH and DONE.
REQ-009 SHALL move from IDLE or DONE to ACCUM on i_frame_start, clearing o_inlier_cnt, o_sq_sum and o_err.
REQ-010 SHALL, on i_frame_start in ACCUM, clear the statistics, clear all in-flight valid bits and remain in ACCUM.
REQ-011 SHALL move from ACCUM to FLUSH on i_frame_end; when i_frame_start and i_frame_end coincide, i_frame_start wins and i_frame_end is ignored.
REQ-012 SHALL ignore i_frame_start and i_frame_end while in FLUSH.
REQ-013 SHALL stay in FLUSH exactly LAT+2 cycles, then enter DONE and pulse o_done high for one cycle.
REQ-014 SHALL hold the statistics in DONE until the next i_frame_start.
REQ-015 SHALL enter i_valid into the pipeline only in ACCUM, including the cycle in which i_frame_end is sampled; i_valid in any other state SHALL be discarded.
REQ-016 SHALL delay the gated i_valid and i_idx1_x/y by exactly LAT stages.
REQ-017 SHALL form a pair when the delayed valid and i_proj_valid are both high in the same cycle.
REQ-018 SHALL, when exactly one of the delayed valid and i_proj_valid is high, set o_err and drop the sample; o_err SHALL be cleared only by i_frame_start or reset.
REQ-019 SHALL register stage 1 as dx = zero-extended idx1_x minus zero-extended proj_x, and dy likewise, with widths H_BW+1 and V_BW+1.
REQ-020 SHALL register stage 2 with o_diffs_x/y, o_inlier and o_valid, and SHALL update the statistics on the same clock edge; end-to-end latency is LAT+2 cycles from i_valid to o_valid.
REQ-021 SHALL set o_inlier = 1 when r_mode = 0; when r_mode = 1, o_inlier = (|dx| <= r_thr) and (|dy| <= r_thr).
REQ-022 SHALL, on each inlier, add dx^2+dy^2 to o_sq_sum and add 1 to o_inlier_cnt, each saturating at all-ones with no wrap.
REQ-023 SHALL hold o_diffs_x/y and o_inlier at their last values when o_valid = 0.

Reset
REQ-024 SHALL, on i_rst_n low, asynchronously drive every output to 0, clear all pipeline valid bits and the flush counter, and enter IDLE.
REQ-025 SHALL, when reset is asserted mid-frame, not produce o_done and not keep any in-flight sample.

Verification
REQ-026 SHALL be verified with these directed scenarios (LAT=11, H_BW=10, V_BW=9, ACC_BW=32 unless noted):
- r_mode=0; i_valid with idx1=(100,50) at t0; i_proj_valid with proj=(97,55) at t0+11 -> at t0+13: o_valid=1, dx=3, dy=-5, o_inlier=1, o_sq_sum=34, o_inlier_cnt=1.
- r_mode=1, r_thr=4, same stimulus -> o_valid=1, o_inlier=0, o_sq_sum=0, o_inlier_cnt=0.
- 3 samples each with dx=dy=1, the last coinciding with i_frame_end at t1 -> o_done high only at t1+14; o_inlier_cnt=3, o_sq_sum=6, held in DONE.
- i_valid at t0 with no i_proj_valid at t0+11 -> o_err=1 at t0+12, no o_valid; o_err stays 1 until i_frame_start.
- ACC_BW=8, two inliers with dx=dy=10 -> o_sq_sum=200, then 255 (saturated).
- i_rst_n low during FLUSH -> all outputs 0 immediately, state IDLE, no o_done; i_valid in IDLE afterwards -> no o_valid.
